// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the I2C target register bridge: FSM states and bus constants.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;
endpackage

// File: rtl/i2c_in_cond.sv
`timescale 1ns/1ps
// SCL/SDA conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch filter,
// then edge and START/STOP detection on the filtered levels.
module i2c_in_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_f,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  // Bits [1:0] are the synchronizer; bits [FILTER_LEN:1] form the filter window.
  logic [FILTER_LEN:0] r_sh_scl;
  logic [FILTER_LEN:0] r_sh_sda;
  logic                r_scl_f;
  logic                r_sda_f;
  logic                r_scl_d;
  logic                r_sda_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sh_scl <= '1;
      r_sh_sda <= '1;
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_sh_scl <= {r_sh_scl[FILTER_LEN-1:0], i_scl};
      r_sh_sda <= {r_sh_sda[FILTER_LEN-1:0], i_sda};
      if (&r_sh_scl[FILTER_LEN:1])       r_scl_f <= 1'b1;
      else if (~|r_sh_scl[FILTER_LEN:1]) r_scl_f <= 1'b0;
      if (&r_sh_sda[FILTER_LEN:1])       r_sda_f <= 1'b1;
      else if (~|r_sh_sda[FILTER_LEN:1]) r_sda_f <= 1'b0;
      r_scl_d <= r_scl_f;
      r_sda_d <= r_sda_f;
    end
  end

  assign o_sda_f    = r_sda_f;
  assign o_scl_rise = r_scl_f & ~r_scl_d;
  assign o_scl_fall = ~r_scl_f & r_scl_d;
  // SCL must be stably high across the SDA transition to count as a bus event.
  assign o_start    = ~r_sda_f & r_sda_d & r_scl_f & r_scl_d;
  assign o_stop     = r_sda_f & ~r_sda_d & r_scl_f & r_scl_d;
endmodule

// File: rtl/i2c_target_regbridge.sv
`timescale 1ns/1ps
// I2C target that maps register-pointer transactions onto a parallel
// register read/write port. SCL is input-only; no clock stretching.
module i2c_target_regbridge
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h2A,
  parameter int                    PTR_W       = 4,
  parameter int                    FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic [PTR_W-1:0]      rd_addr,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  rd_strobe,
  output logic                  busy
);
  logic w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_in_cond #(.FILTER_LEN(FILTER_LEN)) u_in_cond (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda_f    (w_sda_f),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_e            r_state, w_state_nxt;
  logic [3:0]            r_bitcnt, w_bitcnt_nxt;
  logic [I2C_BYTE_W-1:0] r_shift, w_shift_nxt, w_rx_byte;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]      r_wr_addr, w_wr_addr_nxt;
  logic [I2C_BYTE_W-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_sda_oe, w_sda_oe_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_wr_strobe, w_wr_strobe_nxt;
  logic                  r_rd_strobe, w_rd_strobe_nxt;

  assign w_rx_byte = {r_shift[I2C_BYTE_W-2:0], w_sda_f};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_rd_strobe <= w_rd_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bitcnt_nxt    = r_bitcnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_wr_strobe_nxt = 1'b0;
    w_rd_strobe_nxt = 1'b0;
    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_rx_byte;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              w_bitcnt_nxt = '0;
              if (r_state == ST_ADDR) begin
                if (w_rx_byte[7:1] == TARGET_ADDR) begin
                  w_state_nxt = ST_ADDR_ACK;
                  w_busy_nxt  = 1'b1;
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_nxt   = w_rx_byte[PTR_W-1:0];
                w_state_nxt = ST_PTR_ACK;
              end else begin
                w_wr_addr_nxt   = r_ptr;
                w_wr_data_nxt   = w_rx_byte;
                w_wr_strobe_nxt = 1'b1;
                w_ptr_nxt       = r_ptr + 1'b1;
                w_state_nxt     = ST_WR_ACK;
              end
            end
          end
        end
        // First falling edge asserts the ACK, the second releases it and moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_bitcnt_nxt = '0;
              if (r_state != ST_ADDR_ACK) begin
                w_state_nxt = ST_WR_DATA;
              end else if (r_shift[0] == RW_READ) begin
                w_shift_nxt     = rd_data;
                w_sda_oe_nxt    = ~rd_data[7];
                w_rd_strobe_nxt = 1'b1;
                w_state_nxt     = ST_RD_DATA;
              end else begin
                w_state_nxt = ST_PTR;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_ptr_nxt    = r_ptr + 1'b1;
              w_bitcnt_nxt = '0;
              w_state_nxt  = ST_RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[I2C_BYTE_W-2:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[I2C_BYTE_W-2];
            end
          end
        end
        // bitcnt==1 marks "host ACKed, reload on the coming falling edge".
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_f) begin
              w_state_nxt = ST_IGNORE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_bitcnt_nxt = 4'd1;
            end
          end else if (w_scl_fall && r_bitcnt == 4'd1) begin
            w_shift_nxt     = rd_data;
            w_sda_oe_nxt    = ~rd_data[7];
            w_rd_strobe_nxt = 1'b1;
            w_bitcnt_nxt    = '0;
            w_state_nxt     = ST_RD_DATA;
          end
        end
        ST_IDLE, ST_IGNORE: w_sda_oe_nxt = 1'b0;
        default:            w_state_nxt  = ST_IDLE;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_addr   = r_ptr;
  assign rd_strobe = r_rd_strobe;
  assign busy      = r_busy;
endmodule

// File: tb/tb_i2c_target_regbridge.sv
`timescale 1ns/1ps
// Bench for i2c_target_regbridge: a bit-banged I2C host plus a register
// file model returning rd_addr*0x11.
module tb_i2c_target_regbridge;
  localparam int Q = 100;  // quarter SCL period, 10 clk

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_h, sda_h;
  logic       scl_in, sda_in, sda_oe, wr_strobe, rd_strobe, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  assign scl_in  = scl_h;
  assign sda_in  = sda_h & ~sda_oe;
  assign rd_data = {rd_addr, rd_addr};

  i2c_target_regbridge #(.TARGET_ADDR(7'h2A), .PTR_W(4), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_strobe (rd_strobe),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [11:0] wr_log[$];
  int rd_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
    if (rd_strobe) rd_cnt++;
    if (sda_oe)    oe_cnt++;
    if (busy)      busy_cnt++;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_h = 1'b0; #Q; scl_h = 1'b0;
  endtask
  task automatic i2c_rstart();
    #Q sda_h = 1'b1; #Q scl_h = 1'b1; #Q sda_h = 1'b0; #Q scl_h = 1'b0;
  endtask
  task automatic i2c_stop();
    #Q sda_h = 1'b0; #Q scl_h = 1'b1; #Q sda_h = 1'b1; #Q;
  endtask
  task automatic i2c_bit(input logic b, input logic glitch, output logic r);
    #Q sda_h = b;
    #Q scl_h = 1'b1;
    #Q r = sda_in;
    if (glitch) begin
      #20 scl_h = 1'b0;
      #10 scl_h = 1'b1;
      #(Q-30);
    end else begin
      #Q;
    end
    scl_h = 1'b0;
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic [7:0] gl, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], gl[i], r);
    i2c_bit(1'b1, 1'b0, ack);
  endtask
  task automatic rd_byte(input logic ack_in, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    i2c_bit(ack_in, 1'b0, r);
  endtask

  typedef struct {
    logic [7:0] addr, ptr, data;
    logic       exp_ack;
    int         exp_nwr;
    logic [3:0] exp_wa;
    logic [7:0] exp_wd;
    logic [3:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int         wr0, oe0, b0, rd0;

    vecs[0] = '{8'h54, 8'h03, 8'hA5, 1'b0, 1, 4'h3, 8'hA5, 4'h4};
    vecs[1] = '{8'h54, 8'h1F, 8'h3C, 1'b0, 1, 4'hF, 8'h3C, 4'h0};
    vecs[2] = '{8'h56, 8'h01, 8'h77, 1'b1, 0, 4'h0, 8'h00, 4'h0};
    vecs[3] = '{8'h54, 8'h08, 8'h00, 1'b0, 1, 4'h8, 8'h00, 4'h9};
    vecs[4] = '{8'hD4, 8'h02, 8'h11, 1'b1, 0, 4'h0, 8'h00, 4'h9};
    vecs[5] = '{8'h54, 8'hF6, 8'hFF, 1'b0, 1, 4'h6, 8'hFF, 4'h7};

    reset = 1'b1; scl_h = 1'b1; sda_h = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst sda_oe", sda_oe, 0);
    check("rst wr_strobe", wr_strobe, 0);
    check("rst rd_strobe", rd_strobe, 0);
    check("rst busy", busy, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst rd_addr", rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    #Q;

    for (int i = 0; i < 6; i++) begin
      wr0 = wr_log.size(); oe0 = oe_cnt; b0 = busy_cnt;
      i2c_start();
      wr_byte(vecs[i].addr, 8'h00, a0);
      wr_byte(vecs[i].ptr, 8'h00, a1);
      wr_byte(vecs[i].data, 8'h00, a2);
      i2c_stop();
      check($sformatf("v%0d addr_ack", i), a0, vecs[i].exp_ack);
      check($sformatf("v%0d ptr_ack", i), a1, vecs[i].exp_ack);
      check($sformatf("v%0d data_ack", i), a2, vecs[i].exp_ack);
      check($sformatf("v%0d n_wr", i), wr_log.size() - wr0, vecs[i].exp_nwr);
      if (vecs[i].exp_nwr != 0 && wr_log.size() > wr0)
        check($sformatf("v%0d wr_addr_data", i), wr_log[wr0], {vecs[i].exp_wa, vecs[i].exp_wd});
      check($sformatf("v%0d rd_addr", i), rd_addr, vecs[i].exp_rd);
      check($sformatf("v%0d busy_after", i), busy, 0);
      check($sformatf("v%0d busy_seen", i), busy_cnt != b0, !vecs[i].exp_ack);
      check($sformatf("v%0d oe_seen", i), oe_cnt != oe0, !vecs[i].exp_ack);
      #Q;
    end

    // Write burst across two data bytes
    wr0 = wr_log.size();
    i2c_start();
    wr_byte(8'h54, 8'h00, a0); wr_byte(8'h03, 8'h00, a1);
    wr_byte(8'hA5, 8'h00, a2); wr_byte(8'h5A, 8'h00, a3);
    i2c_stop();
    check("burst acks", {a0, a1, a2, a3}, 4'b0000);
    check("burst n_wr", wr_log.size() - wr0, 2);
    if (wr_log.size() >= wr0 + 2) begin
      check("burst wr0", wr_log[wr0], {4'h3, 8'hA5});
      check("burst wr1", wr_log[wr0+1], {4'h4, 8'h5A});
    end
    check("burst rd_addr", rd_addr, 5);
    check("burst busy", busy, 0);
    #Q;

    // Random read with wrap from 0xF to 0x0
    rd0 = rd_cnt;
    i2c_start();
    wr_byte(8'h54, 8'h00, a0); wr_byte(8'h0E, 8'h00, a1);
    i2c_rstart();
    wr_byte(8'h55, 8'h00, a2);
    rd_byte(1'b0, d0); rd_byte(1'b0, d1); rd_byte(1'b1, d2);
    i2c_stop();
    check("rdrand acks", {a0, a1, a2}, 3'b000);
    check("rdrand byte0", d0, 8'hEE);
    check("rdrand byte1", d1, 8'hFF);
    check("rdrand byte2", d2, 8'h00);
    check("rdrand n_rd", rd_cnt - rd0, 3);
    check("rdrand rd_addr", rd_addr, 1);
    check("rdrand busy", busy, 0);
    #Q;

    // One-clk SCL glitch inside the address byte
    wr0 = wr_log.size();
    i2c_start();
    wr_byte(8'h54, 8'h10, a0); wr_byte(8'h02, 8'h00, a1); wr_byte(8'h77, 8'h00, a2);
    i2c_stop();
    check("glitch acks", {a0, a1, a2}, 3'b000);
    check("glitch n_wr", wr_log.size() - wr0, 1);
    if (wr_log.size() > wr0) check("glitch wr", wr_log[wr0], {4'h2, 8'h77});
    #Q;

    // Reset while the target drives a 0 data bit
    i2c_start();
    wr_byte(8'h54, 8'h00, a0); wr_byte(8'h00, 8'h00, a1);
    i2c_rstart();
    wr_byte(8'h55, 8'h00, a2);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, 1'b0, a3);
    #Q;
    check("rstrd oe_before", sda_oe, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstrd oe_after", sda_oe, 0);
    check("rstrd rd_addr", rd_addr, 0);
    check("rstrd busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    sda_h = 1'b1; #Q scl_h = 1'b1; #Q;
    i2c_start();
    wr_byte(8'h54, 8'h00, a0); wr_byte(8'h05, 8'h00, a1);
    i2c_stop();
    check("rstrd reack", {a0, a1}, 2'b00);
    check("rstrd ptr", rd_addr, 5);
    #Q;

    // Pointer-only write, then a read from that pointer
    wr0 = wr_log.size(); rd0 = rd_cnt;
    i2c_start();
    wr_byte(8'h54, 8'h00, a0); wr_byte(8'h07, 8'h00, a1);
    i2c_stop();
    check("ptronly n_wr", wr_log.size() - wr0, 0);
    check("ptronly rd_addr", rd_addr, 7);
    #Q;
    i2c_start();
    wr_byte(8'h55, 8'h00, a0);
    rd_byte(1'b1, d0);
    i2c_stop();
    check("ptronly ack", a0, 0);
    check("ptronly byte", d0, 8'h77);
    check("ptronly n_rd", rd_cnt - rd0, 1);
    check("ptronly rd_addr_after", rd_addr, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
